rom_dl_sequencer: RTL and testbench



---
 rtl/rom_dl_sequencer_pkg.sv | 36 +++
 rtl/rom_dl_sequencer_if.sv | 38 +++
 rtl/rom_region_decode.sv | 38 +++
 rtl/rom_dl_sequencer.sv | 151 +++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_dl_sequencer_pkg.sv
// Shared types and default ROM map constants for the download sequencer.
// The defaults describe the Squash ROM image: four regions packed into 64 KiB.
package rom_dl_pkg;

   // Width of the hps_io byte address bus.
   localparam int unsigned IOCTL_AW = 25;

   // Default local address width and region bases for the Squash ROM map.
   localparam int unsigned DEF_ADDR_W      = 17;
   localparam int unsigned DEF_R1_BASE     = 32'h0_8000;
   localparam int unsigned DEF_R2_BASE     = 32'h0_C000;
   localparam int unsigned DEF_R3_BASE     = 32'h0_E000;
   localparam int unsigned DEF_TOTAL_BYTES = 32'h1_0000;
   localparam int unsigned DEF_SETTLE_CYC  = 16;

   localparam int unsigned NUM_REGIONS = 4;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StRun,
      StError
   } dl_state_e;

   typedef logic [1:0] region_t;

   // One-hot write strobe for a region index.
   function automatic logic [NUM_REGIONS-1:0] region_onehot(input region_t r);
      logic [NUM_REGIONS-1:0] oh;
      oh    = '0;
      oh[r] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rom_dl_sequencer_if.sv
// Download-side bus: hps_io ioctl byte stream in, region-decoded ROM writes out.
// master = hps_io/core side, slave = the sequencer.
interface rom_dl_sequencer_if
   import rom_dl_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

   logic                ioctl_download;
   logic                ioctl_wr;
   logic [IOCTL_AW-1:0] ioctl_addr;
   logic [7:0]          ioctl_dout;

   logic [ADDR_W-1:0]      dn_addr;
   logic [7:0]             dn_data;
   logic [NUM_REGIONS-1:0] dn_we;

   modport master (
      output ioctl_download,
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout,
      input  dn_addr,
      input  dn_data,
      input  dn_we
   );

   modport slave (
      input  ioctl_download,
      input  ioctl_wr,
      input  ioctl_addr,
      input  ioctl_dout,
      output dn_addr,
      output dn_data,
      output dn_we
   );

endinterface

// File: rtl/rom_region_decode.sv
// Combinational image-address decode: picks the ROM region, the offset inside
// it, and whether the address lies inside the expected image at all.
module rom_region_decode
   import rom_dl_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned R1_BASE     = DEF_R1_BASE,
   parameter int unsigned R2_BASE     = DEF_R2_BASE,
   parameter int unsigned R3_BASE     = DEF_R3_BASE,
   parameter int unsigned TOTAL_BYTES = DEF_TOTAL_BYTES
) (
   input  logic [IOCTL_AW-1:0] addr,
   output region_t             region,
   output logic [ADDR_W-1:0]   offset,
   output logic                in_range
);

   logic [IOCTL_AW-1:0] base;

   // Highest matching base wins; region 0 starts at address 0.
   always_comb begin
      region = 2'd0;
      base   = '0;
      if (addr >= IOCTL_AW'(R3_BASE)) begin
         region = 2'd3;
         base   = IOCTL_AW'(R3_BASE);
      end else if (addr >= IOCTL_AW'(R2_BASE)) begin
         region = 2'd2;
         base   = IOCTL_AW'(R2_BASE);
      end else if (addr >= IOCTL_AW'(R1_BASE)) begin
         region = 2'd1;
         base   = IOCTL_AW'(R1_BASE);
      end
      offset   = ADDR_W'(addr - base);
      in_range = addr < IOCTL_AW'(TOTAL_BYTES);
   end

endmodule

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: forwards ioctl bytes to the four core ROM regions,
// keeps a byte count and additive checksum, validates image length, and owns
// the core reset (held until a good image has loaded and settled).
module rom_dl_sequencer
   import rom_dl_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned R1_BASE     = DEF_R1_BASE,
   parameter int unsigned R2_BASE     = DEF_R2_BASE,
   parameter int unsigned R3_BASE     = DEF_R3_BASE,
   parameter int unsigned TOTAL_BYTES = DEF_TOTAL_BYTES,
   parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC
) (
   input  logic              clk_sys,
   input  logic              reset,
   rom_dl_sequencer_if.slave dl,
   input  logic              user_reset,
   output logic              core_reset,
   output logic [ADDR_W:0]   byte_cnt,
   output logic [7:0]        checksum,
   output logic              dl_ok,
   output logic              dl_err
);

   localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   dl_state_e           state_q;
   logic                download_q;
   logic                ovf_q;
   logic [SETTLE_W-1:0] settle_q;

   region_t           wr_region;
   logic [ADDR_W-1:0] wr_offset;
   logic              wr_in_range;

   logic            dl_rise;
   logic            dl_fall;
   logic            wr_ok;
   logic            wr_bad;
   logic            ovf_d;
   logic            cnt_sat;
   logic [ADDR_W:0] cnt_d;
   logic            len_ok;

   rom_region_decode #(
      .ADDR_W      (ADDR_W),
      .R1_BASE     (R1_BASE),
      .R2_BASE     (R2_BASE),
      .R3_BASE     (R3_BASE),
      .TOTAL_BYTES (TOTAL_BYTES)
   ) u_decode (
      .addr     (dl.ioctl_addr),
      .region   (wr_region),
      .offset   (wr_offset),
      .in_range (wr_in_range)
   );

   // Edge detect, write qualification and the length verdict, which must see
   // a write landing in the same cycle as the download falling edge.
   always_comb begin
      dl_rise = dl.ioctl_download & ~download_q;
      dl_fall = ~dl.ioctl_download & download_q;
      wr_ok   = (state_q == StLoad) & dl.ioctl_wr & wr_in_range;
      wr_bad  = (state_q == StLoad) & dl.ioctl_wr & ~wr_in_range;
      ovf_d   = ovf_q | wr_bad;
      cnt_sat = &byte_cnt;
      cnt_d   = byte_cnt;
      if (wr_ok && !cnt_sat) begin
         cnt_d = byte_cnt + (ADDR_W + 1)'(1);
      end
      len_ok = (cnt_d == (ADDR_W + 1)'(TOTAL_BYTES)) & ~ovf_d;
   end

   // Sequencer FSM with all outputs registered; a download rising edge
   // restarts loading from any state.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= StIdle;
         download_q <= 1'b0;
         ovf_q      <= 1'b0;
         settle_q   <= '0;
         dl.dn_we   <= '0;
         dl.dn_addr <= '0;
         dl.dn_data <= '0;
         byte_cnt   <= '0;
         checksum   <= '0;
         dl_ok      <= 1'b0;
         dl_err     <= 1'b0;
         core_reset <= 1'b1;
      end else begin
         download_q <= dl.ioctl_download;
         dl.dn_we   <= '0;
         if (dl_rise) begin
            state_q    <= StLoad;
            ovf_q      <= 1'b0;
            byte_cnt   <= '0;
            checksum   <= '0;
            dl_ok      <= 1'b0;
            dl_err     <= 1'b0;
            core_reset <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  core_reset <= 1'b1;
               end
               StLoad: begin
                  core_reset <= 1'b1;
                  ovf_q      <= ovf_d;
                  if (wr_ok) begin
                     dl.dn_we   <= region_onehot(wr_region);
                     dl.dn_addr <= wr_offset;
                     dl.dn_data <= dl.ioctl_dout;
                     byte_cnt   <= cnt_d;
                     checksum   <= checksum + dl.ioctl_dout;
                  end
                  if (dl_fall) begin
                     if (len_ok) begin
                        dl_ok    <= 1'b1;
                        settle_q <= SETTLE_W'(SETTLE_CYC - 1);
                        state_q  <= StSettle;
                     end else begin
                        dl_err  <= 1'b1;
                        state_q <= StError;
                     end
                  end
               end
               StSettle: begin
                  if (settle_q == '0) begin
                     state_q    <= StRun;
                     core_reset <= 1'b0;
                  end else begin
                     settle_q   <= settle_q - SETTLE_W'(1);
                     core_reset <= 1'b1;
                  end
               end
               StRun: begin
                  core_reset <= user_reset;
               end
               StError: begin
                  core_reset <= 1'b1;
               end
               default: begin
                  state_q    <= StIdle;
                  core_reset <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer on a 1/16-scale ROM map (4 KiB image, same
// region proportions) so several full downloads fit in a short run.
module tb_rom_dl_sequencer;
   import rom_dl_pkg::*;

   localparam int unsigned AW       = 17;
   localparam int unsigned TB_R1    = 32'h800;
   localparam int unsigned TB_R2    = 32'hC00;
   localparam int unsigned TB_R3    = 32'hE00;
   localparam int unsigned TB_TOTAL = 32'h1000;
   localparam int unsigned TB_SETTLE = 16;

   typedef struct {
      logic [3:0]    we;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } exp_t;

   typedef struct {
      logic [24:0]   addr;
      logic [7:0]    data;
      logic [3:0]    we;
      logic [AW-1:0] off;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          user_reset;
   logic          core_reset;
   logic [AW:0]   byte_cnt;
   logic [7:0]    checksum;
   logic          dl_ok;
   logic          dl_err;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   int   reg_cnt[4] = '{0, 0, 0, 0};
   exp_t mon_e;

   rom_dl_sequencer_if #(.ADDR_W(AW)) dl_if ();

   rom_dl_sequencer #(
      .ADDR_W      (AW),
      .R1_BASE     (TB_R1),
      .R2_BASE     (TB_R2),
      .R3_BASE     (TB_R3),
      .TOTAL_BYTES (TB_TOTAL),
      .SETTLE_CYC  (TB_SETTLE)
   ) dut (
      .clk_sys    (clk),
      .reset      (rst),
      .dl         (dl_if),
      .user_reset (user_reset),
      .core_reset (core_reset),
      .byte_cnt   (byte_cnt),
      .checksum   (checksum),
      .dl_ok      (dl_ok),
      .dl_err     (dl_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   // Reference region map for the scaled image.
   function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
      exp_t e;
      e.data = d;
      if (a >= 25'(TB_R3)) begin
         e.we = 4'b1000; e.addr = AW'(a - 25'(TB_R3));
      end else if (a >= 25'(TB_R2)) begin
         e.we = 4'b0100; e.addr = AW'(a - 25'(TB_R2));
      end else if (a >= 25'(TB_R1)) begin
         e.we = 4'b0010; e.addr = AW'(a - 25'(TB_R1));
      end else begin
         e.we = 4'b0001; e.addr = AW'(a);
      end
      return e;
   endfunction

   task automatic start_dl();
      @(negedge clk);
      dl_if.ioctl_wr       = 1'b0;
      dl_if.ioctl_download = 1'b1;
   endtask

   task automatic end_dl();
      @(negedge clk);
      dl_if.ioctl_wr       = 1'b0;
      dl_if.ioctl_download = 1'b0;
   endtask

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit push,
                          input bit drop);
      @(negedge clk);
      dl_if.ioctl_wr   = 1'b1;
      dl_if.ioctl_addr = a;
      dl_if.ioctl_dout = d;
      if (drop) dl_if.ioctl_download = 1'b0;
      if (push) sb_q.push_back(model(a, d));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dn_we"}, 32'(dl_if.dn_we), 32'h0);
      chk({tag, "_dn_addr"}, 32'(dl_if.dn_addr), 32'h0);
      chk({tag, "_dn_data"}, 32'(dl_if.dn_data), 32'h0);
      chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'h0);
      chk({tag, "_checksum"}, 32'(checksum), 32'h0);
      chk({tag, "_dl_ok"}, 32'(dl_ok), 32'h0);
      chk({tag, "_dl_err"}, 32'(dl_err), 32'h0);
      chk({tag, "_core_reset"}, 32'(core_reset), 32'h1);
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (dl_if.dn_we != 4'b0000) begin
         for (int i = 0; i < 4; i++) if (dl_if.dn_we[i]) reg_cnt[i]++;
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_we", 32'(dl_if.dn_we), 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_we", 32'(dl_if.dn_we), 32'(mon_e.we));
            chk("sb_addr", 32'(dl_if.dn_addr), 32'(mon_e.addr));
            chk("sb_data", 32'(dl_if.dn_data), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[11];
      logic [7:0] sum;
      logic [7:0] d;
      int         fall_k;
      int         hi_cnt;
      int         rc0[4];

      vecs[0]  = '{addr: 25'h0C05, data: 8'hA5, we: 4'b0100, off: 17'h005};
      vecs[1]  = '{addr: 25'h0000, data: 8'h11, we: 4'b0001, off: 17'h000};
      vecs[2]  = '{addr: 25'h07FF, data: 8'h22, we: 4'b0001, off: 17'h7FF};
      vecs[3]  = '{addr: 25'h0800, data: 8'h33, we: 4'b0010, off: 17'h000};
      vecs[4]  = '{addr: 25'h0BFF, data: 8'h44, we: 4'b0010, off: 17'h3FF};
      vecs[5]  = '{addr: 25'h0C00, data: 8'h55, we: 4'b0100, off: 17'h000};
      vecs[6]  = '{addr: 25'h0DFF, data: 8'h66, we: 4'b0100, off: 17'h1FF};
      vecs[7]  = '{addr: 25'h0E00, data: 8'h77, we: 4'b1000, off: 17'h000};
      vecs[8]  = '{addr: 25'h0FFF, data: 8'h88, we: 4'b1000, off: 17'h1FF};
      vecs[9]  = '{addr: 25'h1000, data: 8'h99, we: 4'b0000, off: 17'h000};
      vecs[10] = '{addr: 25'h0C05, data: 8'h5A, we: 4'b0100, off: 17'h005};

      rst                  = 1'b1;
      user_reset           = 1'b0;
      dl_if.ioctl_download = 1'b0;
      dl_if.ioctl_wr       = 1'b0;
      dl_if.ioctl_addr     = '0;
      dl_if.ioctl_dout     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      @(negedge clk);
      rst = 1'b0;

      // Table vectors: region boundaries, duplicate address, one out-of-range.
      start_dl();
      sum = 8'h00;
      for (int i = 0; i < 11; i++) begin
         wr_byte(vecs[i].addr, vecs[i].data, 1'b0, 1'b0);
         if (vecs[i].we != 4'b0000) begin
            sb_q.push_back(exp_t'{we: vecs[i].we, addr: vecs[i].off, data: vecs[i].data});
            sum = sum + vecs[i].data;
         end
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_we", i), 32'(dl_if.dn_we), 32'(vecs[i].we));
         if (vecs[i].we != 4'b0000) begin
            chk($sformatf("vec%0d_addr", i), 32'(dl_if.dn_addr), 32'(vecs[i].off));
            chk($sformatf("vec%0d_data", i), 32'(dl_if.dn_data), 32'(vecs[i].data));
         end
         @(negedge clk);
         dl_if.ioctl_wr = 1'b0;
      end
      end_dl();
      repeat (2) @(posedge clk);
      #1;
      chk("vec_dl_err", 32'(dl_err), 32'h1);
      chk("vec_dl_ok", 32'(dl_ok), 32'h0);
      chk("vec_byte_cnt", 32'(byte_cnt), 32'd10);
      chk("vec_checksum", 32'(checksum), 32'(sum));
      chk("vec_core_reset", 32'(core_reset), 32'h1);

      // Short download of 100 bytes; then stray writes in ERROR are ignored.
      start_dl();
      sum = 8'h00;
      for (int i = 0; i < 100; i++) begin
         d = 8'($urandom);
         wr_byte(25'(i * 37), d, 1'b1, 1'b0);
         sum = sum + d;
      end
      end_dl();
      repeat (2) @(posedge clk);
      #1;
      chk("short_dl_err", 32'(dl_err), 32'h1);
      chk("short_dl_ok", 32'(dl_ok), 32'h0);
      chk("short_byte_cnt", 32'(byte_cnt), 32'd100);
      chk("short_checksum", 32'(checksum), 32'(sum));
      hi_cnt = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         dl_if.ioctl_wr   = (c % 10 == 0);
         dl_if.ioctl_addr = 25'(c);
         @(posedge clk);
         #1;
         if (core_reset) hi_cnt++;
      end
      dl_if.ioctl_wr = 1'b0;
      chk("err_hold_1000", 32'(hi_cnt), 32'd1000);
      chk("err_byte_cnt_kept", 32'(byte_cnt), 32'd100);

      // Full download; last byte lands in the same cycle as the falling edge.
      start_dl();
      for (int r = 0; r < 4; r++) rc0[r] = reg_cnt[r];
      sum = 8'h00;
      for (int a = 0; a < int'(TB_TOTAL); a++) begin
         wr_byte(25'(a), 8'(a), 1'b1, a == int'(TB_TOTAL) - 1);
         sum = sum + 8'(a);
      end
      fall_k = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         dl_if.ioctl_wr = 1'b0;
         if (!core_reset) begin
            fall_k = k;
            break;
         end
      end
      chk("full_fall_latency", 32'(fall_k), 32'(TB_SETTLE + 1));
      chk("full_dl_ok", 32'(dl_ok), 32'h1);
      chk("full_dl_err", 32'(dl_err), 32'h0);
      chk("full_byte_cnt", 32'(byte_cnt), TB_TOTAL);
      chk("full_checksum_model", 32'(checksum), 32'(sum));
      chk("full_checksum_zero", 32'(checksum), 32'h00);
      chk("full_r0_cnt", 32'(reg_cnt[0] - rc0[0]), TB_R1);
      chk("full_r1_cnt", 32'(reg_cnt[1] - rc0[1]), TB_R2 - TB_R1);
      chk("full_r2_cnt", 32'(reg_cnt[2] - rc0[2]), TB_R3 - TB_R2);
      chk("full_r3_cnt", 32'(reg_cnt[3] - rc0[3]), TB_TOTAL - TB_R3);

      // RUN: user_reset is registered once; a stray write changes nothing.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         user_reset = (i < 3);
         #1;
         if (i == 0) chk("ur_not_comb", 32'(core_reset), 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("ur_pulse%0d", i), 32'(core_reset), 32'(i < 3));
      end
      wr_byte(25'h10, 8'h10, 1'b0, 1'b0);
      @(negedge clk);
      dl_if.ioctl_wr = 1'b0;
      @(posedge clk);
      #1;
      chk("run_wr_ignored_cnt", 32'(byte_cnt), TB_TOTAL);
      chk("run_wr_ignored_sum", 32'(checksum), 32'h00);

      // Full download plus one byte past the end: overflow -> ERROR.
      start_dl();
      @(posedge clk);
      #1;
      chk("rise_core_reset", 32'(core_reset), 32'h1);
      chk("rise_byte_cnt", 32'(byte_cnt), 32'h0);
      chk("rise_dl_ok", 32'(dl_ok), 32'h0);
      for (int a = 0; a < int'(TB_TOTAL); a++) wr_byte(25'(a), 8'(a ^ 3), 1'b1, 1'b0);
      wr_byte(25'(TB_TOTAL), 8'hEE, 1'b0, 1'b0);
      end_dl();
      repeat (2) @(posedge clk);
      #1;
      chk("ovf_dl_err", 32'(dl_err), 32'h1);
      chk("ovf_dl_ok", 32'(dl_ok), 32'h0);
      chk("ovf_byte_cnt", 32'(byte_cnt), TB_TOTAL);
      hi_cnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (core_reset) hi_cnt++;
      end
      chk("ovf_hold", 32'(hi_cnt), 32'd50);

      // Block reset after 500 bytes of a load.
      start_dl();
      for (int i = 0; i < 500; i++) wr_byte(25'(i), ~8'(i), 1'b1, 1'b0);
      @(negedge clk);
      dl_if.ioctl_wr       = 1'b0;
      dl_if.ioctl_download = 1'b0;
      rst                  = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_core_reset", 32'(core_reset), 32'h1);
      chk("idle_dl_ok", 32'(dl_ok), 32'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
